// File: rtl/w5300_multi_socket_entry.sv
// w5300_multi_socket_entry
//   Top-level sequencer for the W5300 driver. Brings the chip up (reset wait,
//   common config, per-socket config, ID handshake), then schedules interrupt
//   service, per-socket receive and per-socket transmit. The active engine's
//   bus request is steered onto the shared w5300_interface control bus.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   if_addr_o/if_wr_data_o/if_req_o   shared interface bus (addr bit10 = RD/WR)
//   if_rd_data_i, if_op_state_i       interface read data / access-complete pulse
//   int_n_i                    W5300 interrupt (async, active-low)
//   eth_tx_req_i               per-socket transmit request (level)
//   {com,sock,tx,rx}_start_o   engine start pulses
//   {com,sock,tx,rx}_done_i    engine completion pulses
//   {com,sock,tx,rx}_req_i/_addr_i/_wr_data_i   engine bus requests
//   sock_sel_o, tx_sel_o, rx_sel_o    socket index handed to the engines
//   ready_o, error_o, err_clr_i       status / error recovery
//
// state        | meaning
// S_INIT       | post-reset wait
// S_CFG_COM    | common register configuration engine running
// S_CFG_SOCK   | per-socket configuration, one iteration per socket
// S_HANDSHAKE  | reading the ID register, retrying on mismatch
// S_IDLE       | scheduler: irq > receive > transmit
// S_IRQ        | reading IR and merging socket bits into rx_pend
// S_RX         | receive engine serving rx_sel
// S_TX         | transmit engine serving tx_sel
// S_ERROR      | parked until err_clr
module w5300_multi_socket_entry #(
  parameter int NUM_SOCKETS       = 1,
  parameter int RESET_WAIT_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES    = 6000,
  parameter int HS_RETRIES        = 4,
  localparam int SEL_W = (NUM_SOCKETS > 1) ? $clog2(NUM_SOCKETS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [10:0]            if_addr_o,
  output logic [15:0]            if_wr_data_o,
  output logic                   if_req_o,
  input  logic [15:0]            if_rd_data_i,
  input  logic                   if_op_state_i,
  input  logic                   int_n_i,
  input  logic [NUM_SOCKETS-1:0] eth_tx_req_i,
  output logic                   com_start_o,
  input  logic                   com_done_i,
  input  logic                   com_req_i,
  input  logic [10:0]            com_addr_i,
  input  logic [15:0]            com_wr_data_i,
  output logic                   sock_start_o,
  input  logic                   sock_done_i,
  input  logic                   sock_req_i,
  input  logic [10:0]            sock_addr_i,
  input  logic [15:0]            sock_wr_data_i,
  output logic                   tx_start_o,
  input  logic                   tx_done_i,
  input  logic                   tx_req_i,
  input  logic [10:0]            tx_addr_i,
  input  logic [15:0]            tx_wr_data_i,
  output logic                   rx_start_o,
  input  logic                   rx_done_i,
  input  logic                   rx_req_i,
  input  logic [10:0]            rx_addr_i,
  input  logic [15:0]            rx_wr_data_i,
  output logic [SEL_W-1:0]       sock_sel_o,
  output logic [SEL_W-1:0]       tx_sel_o,
  output logic [SEL_W-1:0]       rx_sel_o,
  output logic                   ready_o,
  output logic                   error_o,
  input  logic                   err_clr_i
);

  localparam logic        RD     = 1'b1;
  localparam logic [9:0]  ID_REG = 10'h0FE;
  localparam logic [9:0]  IR_REG = 10'h002;
  localparam logic [15:0] ID_VAL = 16'h5300;
  localparam int CNT_MAX = (RESET_WAIT_CYCLES > TIMEOUT_CYCLES) ? RESET_WAIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RET_W   = $clog2(HS_RETRIES + 1);

  typedef enum logic [3:0] {
    S_INIT, S_CFG_COM, S_CFG_SOCK, S_HANDSHAKE, S_IDLE, S_IRQ, S_RX, S_TX, S_ERROR
  } state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [RET_W-1:0]       retry_q;
  logic [1:0]             sync_q;
  logic                   irq_pend_q;
  logic [NUM_SOCKETS-1:0] rx_pend_q;
  logic [SEL_W-1:0]       rx_ptr_q, tx_ptr_q;
  logic [SEL_W-1:0]       sock_sel_q, rx_sel_q, tx_sel_q;
  logic                   com_start_q, sock_start_q, rx_start_q, tx_start_q;
  logic                   ready_q, error_q;

  logic                   done_evt, wd_state, to_error;
  logic [SEL_W-1:0]       rx_pick, tx_pick;

  // First set bit at or after ptr, wrapping: smallest forward distance wins.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_SOCKETS-1:0] mask,
                                               input logic [SEL_W-1:0] ptr);
    logic [SEL_W-1:0] pick;
    int best_d, d;
    pick   = ptr;
    best_d = NUM_SOCKETS;
    for (int i = 0; i < NUM_SOCKETS; i++) begin
      d = (i + NUM_SOCKETS - int'(ptr)) % NUM_SOCKETS;
      if (mask[i] && d < best_d) begin
        best_d = d;
        pick   = SEL_W'(i);
      end
    end
    return pick;
  endfunction

  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] s);
    return (int'(s) == NUM_SOCKETS - 1) ? '0 : s + SEL_W'(1);
  endfunction

  function automatic logic [NUM_SOCKETS-1:0] sel_mask(input logic [SEL_W-1:0] s);
    logic [NUM_SOCKETS-1:0] m;
    for (int i = 0; i < NUM_SOCKETS; i++) m[i] = (int'(s) == i);
    return m;
  endfunction

  always_comb begin
    done_evt = 1'b0;
    case (state_q)
      S_CFG_COM:          done_evt = com_done_i;
      S_CFG_SOCK:         done_evt = sock_done_i;
      S_HANDSHAKE, S_IRQ: done_evt = if_op_state_i;
      S_RX:               done_evt = rx_done_i;
      S_TX:               done_evt = tx_done_i;
      default:            done_evt = 1'b0;
    endcase
    wd_state = !(state_q inside {S_INIT, S_IDLE, S_ERROR});
    // A completion in the timeout cycle takes precedence over the watchdog.
    to_error = (wd_state && int'(cnt_q) == TIMEOUT_CYCLES - 1 && !done_evt) ||
               (state_q == S_HANDSHAKE && if_op_state_i && if_rd_data_i != ID_VAL &&
                int'(retry_q) == HS_RETRIES - 1);
    rx_pick = rr_pick(rx_pend_q, rx_ptr_q);
    tx_pick = rr_pick(eth_tx_req_i, tx_ptr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_INIT;
      cnt_q        <= '0;
      retry_q      <= '0;
      sync_q       <= 2'b11;
      irq_pend_q   <= 1'b0;
      rx_pend_q    <= '0;
      rx_ptr_q     <= '0;
      tx_ptr_q     <= '0;
      sock_sel_q   <= '0;
      rx_sel_q     <= '0;
      tx_sel_q     <= '0;
      com_start_q  <= 1'b0;
      sock_start_q <= 1'b0;
      rx_start_q   <= 1'b0;
      tx_start_q   <= 1'b0;
      ready_q      <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], int_n_i};
      com_start_q  <= 1'b0;
      sock_start_q <= 1'b0;
      rx_start_q   <= 1'b0;
      tx_start_q   <= 1'b0;
      cnt_q        <= (state_q == S_IDLE || state_q == S_ERROR) ? '0 : cnt_q + CNT_W'(1);
      if (!sync_q[1] && state_q != S_ERROR && state_q != S_INIT) irq_pend_q <= 1'b1;

      case (state_q)
        S_INIT: if (int'(cnt_q) == RESET_WAIT_CYCLES - 1) begin
          state_q     <= S_CFG_COM;
          com_start_q <= 1'b1;
          cnt_q       <= '0;
        end
        S_CFG_COM: if (com_done_i) begin
          state_q      <= S_CFG_SOCK;
          sock_sel_q   <= '0;
          sock_start_q <= 1'b1;
          cnt_q        <= '0;
        end
        S_CFG_SOCK: if (sock_done_i) begin
          cnt_q <= '0;  // each socket iteration gets a full watchdog budget
          if (int'(sock_sel_q) == NUM_SOCKETS - 1) begin
            state_q <= S_HANDSHAKE;
            retry_q <= '0;
          end else begin
            sock_sel_q   <= sock_sel_q + SEL_W'(1);
            sock_start_q <= 1'b1;
          end
        end
        S_HANDSHAKE: if (if_op_state_i) begin
          cnt_q <= '0;  // each ID read gets a full watchdog budget
          if (if_rd_data_i == ID_VAL) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end else begin
            retry_q <= retry_q + RET_W'(1);
          end
        end
        S_IDLE: begin
          cnt_q <= '0;
          if (irq_pend_q) begin
            state_q <= S_IRQ;
          end else if (|rx_pend_q) begin
            state_q    <= S_RX;
            rx_sel_q   <= rx_pick;
            rx_start_q <= 1'b1;
          end else if (|eth_tx_req_i) begin
            state_q    <= S_TX;
            tx_sel_q   <= tx_pick;
            tx_start_q <= 1'b1;
          end
        end
        S_IRQ: if (if_op_state_i) begin
          rx_pend_q  <= rx_pend_q | if_rd_data_i[NUM_SOCKETS-1:0];
          irq_pend_q <= 1'b0;
          state_q    <= S_IDLE;
          cnt_q      <= '0;
        end
        S_RX: if (rx_done_i) begin
          rx_pend_q <= rx_pend_q & ~sel_mask(rx_sel_q);
          rx_ptr_q  <= wrap_inc(rx_sel_q);
          state_q   <= S_IDLE;
          cnt_q     <= '0;
        end
        S_TX: if (tx_done_i) begin
          tx_ptr_q <= wrap_inc(tx_sel_q);
          state_q  <= S_IDLE;
          cnt_q    <= '0;
        end
        S_ERROR: if (err_clr_i) begin
          state_q <= S_INIT;
          error_q <= 1'b0;
          cnt_q   <= '0;
        end
        default: state_q <= S_ERROR;
      endcase

      if (to_error) begin
        state_q    <= S_ERROR;
        error_q    <= 1'b1;
        ready_q    <= 1'b0;
        rx_pend_q  <= '0;
        irq_pend_q <= 1'b0;
        rx_ptr_q   <= '0;
        tx_ptr_q   <= '0;
        cnt_q      <= '0;
      end
    end
  end

  // Bus switch: decoded from the current state only, so reset drops it at once.
  always_comb begin
    if_req_o     = 1'b0;
    if_wr_data_o = 16'h0000;
    if_addr_o    = {RD, 10'h000};
    case (state_q)
      S_CFG_COM:   {if_req_o, if_wr_data_o, if_addr_o} = {com_req_i, com_wr_data_i, com_addr_i};
      S_CFG_SOCK:  {if_req_o, if_wr_data_o, if_addr_o} = {sock_req_i, sock_wr_data_i, sock_addr_i};
      S_RX:        {if_req_o, if_wr_data_o, if_addr_o} = {rx_req_i, rx_wr_data_i, rx_addr_i};
      S_TX:        {if_req_o, if_wr_data_o, if_addr_o} = {tx_req_i, tx_wr_data_i, tx_addr_i};
      S_HANDSHAKE: begin if_req_o = 1'b1; if_addr_o = {RD, ID_REG}; end
      S_IRQ:       begin if_req_o = 1'b1; if_addr_o = {RD, IR_REG}; end
      default:     ;
    endcase
  end

  assign com_start_o  = com_start_q;
  assign sock_start_o = sock_start_q;
  assign rx_start_o   = rx_start_q;
  assign tx_start_o   = tx_start_q;
  assign sock_sel_o   = sock_sel_q;
  assign rx_sel_o     = rx_sel_q;
  assign tx_sel_o     = tx_sel_q;
  assign ready_o      = ready_q;
  assign error_o      = error_q;

endmodule

// File: tb/tb_w5300_multi_socket_entry.sv
module tb_w5300_multi_socket_entry;
  localparam int N  = 4;
  localparam int RW = 20;
  localparam int TO = 40;
  localparam int HS = 4;
  localparam logic RD = 1'b1;
  localparam logic [39:0] RST_VEC = {1'b0, 16'h0000, RD, 10'h000, 4'b0000, 6'b000000, 2'b00};
  localparam int W_COM = 0, W_SOCK = 1, W_TX = 2, W_RX = 3, W_REQ = 4, W_ERR = 5;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [10:0] if_addr; logic [15:0] if_wr_data; logic if_req;
  logic [15:0] if_rd_data = 16'h0; logic if_op_state = 1'b0;
  logic int_n = 1'b1; logic [N-1:0] eth_tx_req = '0;
  logic com_start, sock_start, tx_start, rx_start;
  logic com_done = 0, sock_done = 0, tx_done = 0, rx_done = 0;
  logic com_req = 1, sock_req = 1, tx_req = 1, rx_req = 1;
  logic [10:0] com_addr = 11'h101, sock_addr = 11'h202, tx_addr = 11'h303, rx_addr = 11'h404;
  logic [15:0] com_wd = 16'hC0C0, sock_wd = 16'h5050, tx_wd = 16'h7070, rx_wd = 16'h8080;
  logic [1:0] sock_sel, tx_sel, rx_sel;
  logic ready, error, err_clr = 1'b0;

  w5300_multi_socket_entry #(.NUM_SOCKETS(N), .RESET_WAIT_CYCLES(RW),
                             .TIMEOUT_CYCLES(TO), .HS_RETRIES(HS)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_addr_o(if_addr), .if_wr_data_o(if_wr_data), .if_req_o(if_req),
    .if_rd_data_i(if_rd_data), .if_op_state_i(if_op_state), .int_n_i(int_n),
    .eth_tx_req_i(eth_tx_req),
    .com_start_o(com_start), .com_done_i(com_done), .com_req_i(com_req),
    .com_addr_i(com_addr), .com_wr_data_i(com_wd),
    .sock_start_o(sock_start), .sock_done_i(sock_done), .sock_req_i(sock_req),
    .sock_addr_i(sock_addr), .sock_wr_data_i(sock_wd),
    .tx_start_o(tx_start), .tx_done_i(tx_done), .tx_req_i(tx_req),
    .tx_addr_i(tx_addr), .tx_wr_data_i(tx_wd),
    .rx_start_o(rx_start), .rx_done_i(rx_done), .rx_req_i(rx_req),
    .rx_addr_i(rx_addr), .rx_wr_data_i(rx_wd),
    .sock_sel_o(sock_sel), .tx_sel_o(tx_sel), .rx_sel_o(rx_sel),
    .ready_o(ready), .error_o(error), .err_clr_i(err_clr)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  int m_rx_ptr = 0, m_tx_ptr = 0;
  logic [N-1:0] m_rx_pend = '0;

  // Reference arbiter: scan sockets starting at ptr, wrapping.
  function automatic int model_pick(input logic [N-1:0] mask, input int ptr);
    for (int k = 0; k < N; k++) if (mask[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [39:0] out_vec();
    return {if_req, if_wr_data, if_addr, com_start, sock_start, tx_start, rx_start,
            sock_sel, tx_sel, rx_sel, ready, error};
  endfunction

  function automatic logic sig_val(input int id);
    case (id)
      W_COM:   return com_start;
      W_SOCK:  return sock_start;
      W_TX:    return tx_start;
      W_RX:    return rx_start;
      W_REQ:   return if_req;
      W_ERR:   return error;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_sig(input int id, input int budget, output bit ok);
    int n = 0;
    ok = sig_val(id);
    while (!ok && n < budget) begin
      tick(); n++;
      ok = sig_val(id);
    end
  endtask

  task automatic pulse_done(input int id);
    case (id)
      W_COM:  com_done = 1'b1;
      W_SOCK: sock_done = 1'b1;
      W_TX:   tx_done = 1'b1;
      default: rx_done = 1'b1;
    endcase
    tick();
    com_done = 0; sock_done = 0; tx_done = 0; rx_done = 0;
  endtask

  task automatic pulse_op(input logic [15:0] d);
    if_rd_data = d; if_op_state = 1'b1;
    tick();
    if_op_state = 1'b0;
  endtask

  task automatic pulse_int();
    int_n = 1'b0; tick(); tick(); int_n = 1'b1;
  endtask

  task automatic config_quiet();
    bit ok;
    wait_sig(W_COM, RW + 10, ok);
    n_total++; if (!ok) $display("FAIL cfg_com_wait: got no com_start, expected one"); else n_pass++;
    pulse_done(W_COM);
    for (int s = 0; s < N; s++) begin
      wait_sig(W_SOCK, 10, ok);
      n_total++; if (!ok) $display("FAIL cfg_sock_wait[%0d]: got no sock_start, expected one", s); else n_pass++;
      pulse_done(W_SOCK);
    end
  endtask

  task automatic bring_up_quiet();
    bit ok;
    config_quiet();
    wait_sig(W_REQ, 10, ok);
    n_total++; if (!ok) $display("FAIL hs_wait: got no if_req, expected handshake read"); else n_pass++;
    pulse_op(16'h5300);
    n_total++; if (ready !== 1'b1) $display("FAIL hs_ready: got %b expected 1", ready); else n_pass++;
    m_rx_ptr = 0; m_tx_ptr = 0; m_rx_pend = '0;
  endtask

  task automatic test_reset();
    n_total++;
    if (out_vec() !== RST_VEC) $display("FAIL reset_outputs: got %h expected %h", out_vec(), RST_VEC);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_bringup();
    bit ok;
    int cyc = 0;
    while (!com_start && cyc < RW + 10) begin tick(); cyc++; end
    n_total++; if (cyc != RW) $display("FAIL init_wait: got %0d cycles expected %0d", cyc, RW); else n_pass++;
    n_total++; if (if_addr !== com_addr) $display("FAIL mux_com: got %h expected %h", if_addr, com_addr); else n_pass++;
    pulse_done(W_COM);
    n_total++; if (com_start !== 1'b0) $display("FAIL com_pulse_width: got %b expected 0", com_start); else n_pass++;
    for (int s = 0; s < N; s++) begin
      wait_sig(W_SOCK, 10, ok);
      n_total++; if (!ok) $display("FAIL sock_start[%0d]: got 0 expected 1", s); else n_pass++;
      n_total++; if (sock_sel !== 2'(s)) $display("FAIL sock_sel[%0d]: got %0d expected %0d", s, sock_sel, s); else n_pass++;
      pulse_done(W_SOCK);
    end
    n_total++; if (sock_start !== 1'b0) $display("FAIL sock_extra: got %b expected 0", sock_start); else n_pass++;
    n_total++;
    if ({if_req, if_addr} !== {1'b1, RD, 10'h0FE}) $display("FAIL hs_bus: got %b/%h expected 1/%h", if_req, if_addr, {RD, 10'h0FE});
    else n_pass++;
    n_total++; if (ready !== 1'b0) $display("FAIL ready_early: got %b expected 0", ready); else n_pass++;
    pulse_op(16'h5300);
    n_total++; if (ready !== 1'b1) $display("FAIL ready_after_id: got %b expected 1", ready); else n_pass++;
    n_total++;
    if ({if_req, if_wr_data, if_addr} !== {1'b0, 16'h0, RD, 10'h000}) $display("FAIL idle_bus: got %b/%h/%h expected default", if_req, if_wr_data, if_addr);
    else n_pass++;
    m_rx_ptr = 0; m_tx_ptr = 0; m_rx_pend = '0;
  endtask

  task automatic test_rx_service();
    bit ok;
    int seen = 0;
    int_n = 1'b0; tick(); tick(); int_n = 1'b1; tick();
    n_total++; if (if_req !== 1'b0) $display("FAIL irq_latency_early: got %b expected 0", if_req); else n_pass++;
    tick();
    n_total++;
    if ({if_req, if_addr} !== {1'b1, RD, 10'h002}) $display("FAIL irq_read: got %b/%h expected 1/%h", if_req, if_addr, {RD, 10'h002});
    else n_pass++;
    pulse_op(16'hFF05);
    wait_sig(W_RX, 10, ok);
    n_total++; if (rx_sel !== 2'd0 || !ok) $display("FAIL rx_first: got %0d/%b expected 0/1", rx_sel, ok); else n_pass++;
    n_total++; if (if_addr !== rx_addr || if_wr_data !== rx_wd) $display("FAIL mux_rx: got %h/%h expected %h/%h", if_addr, if_wr_data, rx_addr, rx_wd); else n_pass++;
    pulse_done(W_RX);
    n_total++; if (rx_start !== 1'b0) $display("FAIL rx_start_on_done: got %b expected 0", rx_start); else n_pass++;
    wait_sig(W_RX, 10, ok);
    n_total++; if (rx_sel !== 2'd2 || !ok) $display("FAIL rx_second: got %0d/%b expected 2/1", rx_sel, ok); else n_pass++;
    pulse_done(W_RX);
    for (int i = 0; i < 6; i++) begin
      if (rx_start || tx_start || if_req) seen++;
      tick();
    end
    n_total++; if (seen != 0) $display("FAIL rx_drained: got %0d activity cycles expected 0", seen); else n_pass++;
    m_rx_ptr = 3; m_rx_pend = '0;
  endtask

  task automatic test_rx_random();
    bit ok;
    logic [15:0] ir;
    int exp;
    for (int it = 0; it < 8; it++) begin
      ir = 16'($urandom);
      pulse_int();
      wait_sig(W_REQ, 10, ok);
      n_total++; if (!ok) $display("FAIL rnd_irq_wait[%0d]: got no if_req expected IR read", it); else n_pass++;
      pulse_op(ir);
      m_rx_pend = m_rx_pend | ir[N-1:0];
      while (m_rx_pend != '0) begin
        exp = model_pick(m_rx_pend, m_rx_ptr);
        wait_sig(W_RX, 10, ok);
        n_total++;
        if (!ok || rx_sel !== 2'(exp)) $display("FAIL rnd_rx_sel ir=%h: got %0d/%b expected %0d", ir, rx_sel, ok, exp);
        else n_pass++;
        pulse_done(W_RX);
        m_rx_pend[exp] = 1'b0;
        m_rx_ptr = (exp + 1) % N;
      end
    end
  endtask

  task automatic test_tx_rr();
    bit ok;
    int exp_sel[4] = '{0, 1, 3, 0};
    eth_tx_req = 4'b1011;
    for (int g = 0; g < 4; g++) begin
      wait_sig(W_TX, 10, ok);
      n_total++;
      if (!ok || tx_sel !== 2'(exp_sel[g])) $display("FAIL tx_rr[%0d]: got %0d/%b expected %0d", g, tx_sel, ok, exp_sel[g]);
      else n_pass++;
      if (g == 0) begin
        n_total++; if (if_wr_data !== tx_wd) $display("FAIL mux_tx: got %h expected %h", if_wr_data, tx_wd); else n_pass++;
      end
      if (g == 3) eth_tx_req = '0;
      pulse_done(W_TX);
    end
    m_tx_ptr = 1;
  endtask

  task automatic test_tx_random();
    bit ok;
    logic [N-1:0] mask, nxt;
    int exp;
    mask = N'($urandom_range(1, 15));
    eth_tx_req = mask;
    for (int it = 0; it < 8; it++) begin
      exp = model_pick(mask, m_tx_ptr);
      wait_sig(W_TX, 10, ok);
      n_total++;
      if (!ok || tx_sel !== 2'(exp)) $display("FAIL rnd_tx_sel mask=%b: got %0d/%b expected %0d", mask, tx_sel, ok, exp);
      else n_pass++;
      nxt = (it < 7) ? N'($urandom_range(1, 15)) : '0;
      eth_tx_req = nxt;
      pulse_done(W_TX);
      m_tx_ptr = (exp + 1) % N;
      mask = nxt;
    end
  endtask

  task automatic test_irq_during_tx();
    bit ok;
    int exp;
    eth_tx_req = 4'b0100;
    exp = model_pick(eth_tx_req, m_tx_ptr);
    wait_sig(W_TX, 10, ok);
    n_total++; if (!ok || tx_sel !== 2'(exp)) $display("FAIL irq_tx_first: got %0d/%b expected %0d", tx_sel, ok, exp); else n_pass++;
    pulse_int(); tick(); tick(); tick();
    pulse_done(W_TX);
    m_tx_ptr = (exp + 1) % N;
    tick();
    n_total++;
    if ({if_req, if_addr, tx_start} !== {1'b1, RD, 10'h002, 1'b0})
      $display("FAIL irq_after_tx: got req=%b addr=%h tx_start=%b expected 1/%h/0", if_req, if_addr, tx_start, {RD, 10'h002});
    else n_pass++;
    pulse_op(16'h0000);
    exp = model_pick(eth_tx_req, m_tx_ptr);
    wait_sig(W_TX, 10, ok);
    n_total++; if (!ok || tx_sel !== 2'(exp)) $display("FAIL irq_tx_resume: got %0d/%b expected %0d", tx_sel, ok, exp); else n_pass++;
    eth_tx_req = '0;
    pulse_done(W_TX);
    m_tx_ptr = (exp + 1) % N;
  endtask

  task automatic test_watchdog();
    bit ok;
    int exp, cyc = 0;
    pulse_int();
    wait_sig(W_REQ, 10, ok);
    pulse_op(16'h0008);
    m_rx_pend = m_rx_pend | 4'b1000;
    exp = model_pick(m_rx_pend, m_rx_ptr);
    wait_sig(W_RX, 10, ok);
    n_total++; if (!ok || rx_sel !== 2'(exp)) $display("FAIL wd_rx_sel: got %0d/%b expected %0d", rx_sel, ok, exp); else n_pass++;
    while (!error && cyc < TO + 10) begin tick(); cyc++; end
    n_total++; if (cyc != TO) $display("FAIL wd_timeout: got %0d cycles expected %0d", cyc, TO); else n_pass++;
    n_total++; if (ready !== 1'b0 || if_req !== 1'b0) $display("FAIL wd_error_outs: got ready=%b req=%b expected 0/0", ready, if_req); else n_pass++;
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    n_total++; if (error !== 1'b0) $display("FAIL err_clr: got %b expected 0", error); else n_pass++;
    bring_up_quiet();
  endtask

  task automatic test_done_at_timeout();
    bit ok;
    int exp;
    pulse_int();
    wait_sig(W_REQ, 10, ok);
    pulse_op(16'h000A);
    m_rx_pend = m_rx_pend | 4'b1010;
    exp = model_pick(m_rx_pend, m_rx_ptr);
    wait_sig(W_RX, 10, ok);
    n_total++; if (!ok || rx_sel !== 2'(exp)) $display("FAIL dt_rx_sel: got %0d/%b expected %0d", rx_sel, ok, exp); else n_pass++;
    repeat (TO - 1) tick();
    pulse_done(W_RX);
    m_rx_pend[exp] = 1'b0; m_rx_ptr = (exp + 1) % N;
    n_total++; if (error !== 1'b0) $display("FAIL done_wins: got error=%b expected 0", error); else n_pass++;
    exp = model_pick(m_rx_pend, m_rx_ptr);
    wait_sig(W_RX, 10, ok);
    n_total++; if (!ok || rx_sel !== 2'(exp)) $display("FAIL dt_rx_next: got %0d/%b expected %0d", rx_sel, ok, exp); else n_pass++;
    pulse_done(W_RX);
    m_rx_pend[exp] = 1'b0; m_rx_ptr = (exp + 1) % N;
  endtask

  task automatic test_hs_error();
    bit ok;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    config_quiet();
    for (int i = 0; i < HS; i++) begin
      wait_sig(W_REQ, 5, ok);
      n_total++; if (!ok) $display("FAIL hs_retry_req[%0d]: got 0 expected 1", i); else n_pass++;
      pulse_op(16'h1234);
      n_total++; if (error !== (i == HS - 1)) $display("FAIL hs_error[%0d]: got %b expected %b", i, error, (i == HS - 1)); else n_pass++;
    end
    n_total++; if (if_req !== 1'b0 || ready !== 1'b0) $display("FAIL hs_error_bus: got req=%b ready=%b expected 0/0", if_req, ready); else n_pass++;
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    n_total++; if (error !== 1'b0 || ready !== 1'b0) $display("FAIL hs_err_clr: got err=%b ready=%b expected 0/0", error, ready); else n_pass++;
    bring_up_quiet();
  endtask

  task automatic test_reset_mid_rx();
    bit ok;
    pulse_int();
    wait_sig(W_REQ, 10, ok);
    pulse_op(16'h0001);
    wait_sig(W_RX, 10, ok);
    n_total++; if (!ok || if_req !== 1'b1) $display("FAIL mid_rx_active: got %b/%b expected 1/1", ok, if_req); else n_pass++;
    tick(); #2;
    rst_n = 1'b0; #1;
    n_total++; if (out_vec() !== RST_VEC) $display("FAIL reset_mid_rx: got %h expected %h", out_vec(), RST_VEC); else n_pass++;
    tick();
    n_total++; if (out_vec() !== RST_VEC) $display("FAIL reset_hold: got %h expected %h", out_vec(), RST_VEC); else n_pass++;
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    test_reset();
    test_bringup();
    test_rx_service();
    test_rx_random();
    test_tx_rr();
    test_tx_random();
    test_irq_during_tx();
    test_watchdog();
    test_done_at_timeout();
    test_hs_error();
    test_reset_mid_rx();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected finish");
    $fatal(1, "bench time limit");
  end
endmodule
